// File: rtl/ext_unit_if.sv
// Immediate-extender bus: raw immediate and mode in, combinational and
// registered extension results out.
interface ext_unit_if #(
  parameter int IMM_W = 16,
  parameter int OUT_W = 32
);
  logic [IMM_W-1:0] imm;
  logic [1:0]       Eop;
  logic             in_valid;
  logic             stall;
  logic [OUT_W-1:0] ext;
  logic [OUT_W-1:0] ext_q;
  logic             out_valid;

  modport master (
    output imm, Eop, in_valid, stall,
    input  ext, ext_q, out_valid
  );

  modport slave (
    input  imm, Eop, in_valid, stall,
    output ext, ext_q, out_valid
  );
endinterface

// File: rtl/ext_unit.sv
// Immediate extender for the MIPS datapath. Produces a same-cycle
// combinational result and a stall-aware, valid-qualified registered copy.
module ext_unit #(
  parameter int IMM_W = 16,
  parameter int OUT_W = 32
) (
  input logic       clk,
  input logic       rst_n,
  ext_unit_if.slave bus
);

  logic [OUT_W-1:0] ext_c;
  logic [OUT_W-1:0] ext_r;
  logic             valid_r;
  logic             s;

  assign s = bus.imm[IMM_W-1];

  // Mode decode: 00 zero-ext, 01 sign-ext, 10 load-upper, 11 branch offset.
  always_comb begin
    ext_c = '0;
    unique case (bus.Eop)
      2'b00:   ext_c = {16'h0000, bus.imm};
      2'b01:   ext_c = {{16{s}}, bus.imm};
      2'b10:   ext_c = {bus.imm, 16'h0000};
      default: ext_c = {{14{s}}, bus.imm, 2'b00};
    endcase
  end

  // Output register: stall freezes everything, otherwise capture on in_valid
  // and drop valid when nothing new arrives (data is kept for inspection).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_r   <= '0;
      valid_r <= 1'b0;
    end else if (!bus.stall) begin
      valid_r <= bus.in_valid;
      if (bus.in_valid) ext_r <= ext_c;
    end
  end

  assign bus.ext       = ext_c;
  assign bus.ext_q     = ext_r;
  assign bus.out_valid = valid_r;

endmodule

// File: tb/tb_ext_unit.sv
// Scoreboard bench for ext_unit: the driver pushes the expected registered
// state for each upcoming edge, a monitor pops and compares after the edge.
module tb_ext_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  typedef struct packed {
    logic        v;
    logic [31:0] q;
  } exp_t;

  exp_t exp_q[$];

  // reference state of the registered view
  logic        m_v = 1'b0;
  logic [31:0] m_q = 32'h0;

  ext_unit_if bus ();

  ext_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // reference extension computed with arithmetic on a signed view of imm
  function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] eop);
    int signed sv;
    sv = int'($signed(imm));
    case (eop)
      2'd0:    return 32'(int'(imm));
      2'd1:    return 32'(sv);
      2'd2:    return 32'(int'(imm) * 65536);
      default: return 32'(sv * 4);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // one cycle of stimulus: drive at negedge, predict next edge, check ext
  task automatic drive(input logic [15:0] imm, input logic [1:0] eop,
                       input logic v, input logic st);
    exp_t e;
    @(negedge clk);
    bus.imm = imm;
    bus.Eop = eop;
    bus.in_valid = v;
    bus.stall = st;
    if (!st) begin
      m_v = v;
      if (v) m_q = ref_ext(imm, eop);
    end
    e.v = m_v;
    e.q = m_q;
    exp_q.push_back(e);
    mon_en = 1'b1;
    #1;
    chk("ext_comb", bus.ext, ref_ext(imm, eop));
  endtask

  // asynchronous reset pulse fully between two rising edges
  task automatic reset_pulse();
    exp_t e;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.stall = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_ext_q", bus.ext_q, 32'h0);
    chk("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("rst_ext_comb", bus.ext, ref_ext(bus.imm, bus.Eop));
    rst_n = 1'b1;
    m_v = 1'b0;
    m_q = 32'h0;
    e.v = 1'b0;
    e.q = 32'h0;
    exp_q.push_back(e);
  endtask

  // monitor: after every rising edge out of reset, pop and compare
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("out_valid", {31'h0, bus.out_valid}, {31'h0, e.v});
          chk("ext_q", bus.ext_q, e.q);
        end else if (mon_en) begin
          chk("scoreboard_underflow", 32'h1, 32'h0);
        end
      end
    end
  end

  initial begin
    bus.imm = 16'h0;
    bus.Eop = 2'b00;
    bus.in_valid = 1'b0;
    bus.stall = 1'b0;
    #1;
    chk("init_ext_q", bus.ext_q, 32'h0);
    chk("init_out_valid", {31'h0, bus.out_valid}, 32'h0);
    #1;
    rst_n = 1'b1;

    // basic zero-extend
    drive(16'h0010, 2'b00, 1'b1, 1'b0);
    chk("zx_const", bus.ext, 32'h00000010);

    // all modes, negative immediate
    drive(16'h8001, 2'b00, 1'b1, 1'b0); chk("m00_neg", bus.ext, 32'h00008001);
    drive(16'h8001, 2'b01, 1'b1, 1'b0); chk("m01_neg", bus.ext, 32'hFFFF8001);
    drive(16'h8001, 2'b10, 1'b1, 1'b0); chk("m10_neg", bus.ext, 32'h80010000);
    drive(16'h8001, 2'b11, 1'b1, 1'b0); chk("m11_neg", bus.ext, 32'hFFFE0004);

    // positive sign-extend / branch, all-ones branch
    drive(16'h7FFF, 2'b01, 1'b1, 1'b0); chk("m01_pos", bus.ext, 32'h00007FFF);
    drive(16'h7FFF, 2'b11, 1'b1, 1'b0); chk("m11_pos", bus.ext, 32'h0001FFFC);
    drive(16'hFFFF, 2'b11, 1'b1, 1'b0); chk("m11_ones", bus.ext, 32'hFFFFFFFC);
    drive(16'hFFFF, 2'b00, 1'b1, 1'b0); chk("m00_ones", bus.ext, 32'h0000FFFF);

    // stall hold, stall wins over in_valid
    drive(16'h1234, 2'b10, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(16'h5678, 2'b10, 1'b1, 1'b1);
    drive(16'h5678, 2'b10, 1'b1, 1'b0);

    // back-to-back then valid drop
    drive(16'hFFFF, 2'b00, 1'b1, 1'b0);
    drive(16'hFFFF, 2'b01, 1'b1, 1'b0);
    drive(16'hFFFF, 2'b10, 1'b1, 1'b0);
    drive(16'hFFFF, 2'b10, 1'b0, 1'b0);
    drive(16'h0000, 2'b01, 1'b0, 1'b0);

    // async reset mid-stream while out_valid is high
    drive(16'hABCD, 2'b01, 1'b1, 1'b0);
    reset_pulse();
    drive(16'h4321, 2'b11, 1'b0, 1'b0);
    drive(16'h4321, 2'b11, 1'b1, 1'b0);

    // randomized traffic with occasional reset pulses
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 49) == 0) reset_pulse();
      else drive(16'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) == 0));
    end
    drive(16'h0, 2'b00, 1'b0, 1'b0);

    @(negedge clk);
    if (exp_q.size() != 0) chk("scoreboard_drain", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ext_unit.md
Name: ext_unit

Overview:
- Immediate extender for the MIPS datapath.
- Widens the 16-bit instruction immediate to 32 bits using one of four modes selected by Eop.
- Provides two views of the result:
  - a combinational output (ext) for same-cycle use in the decode/execute path;
  - a registered, valid-qualified copy (ext_q/out_valid) for pipelined consumers.

Parameters:
- IMM_W, 16, immediate input width; only 16 is supported.
- OUT_W, 32, extended output width; only 32 is supported.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- imm  input  16  raw immediate field, instr[15:0].
- Eop  input  2  extension mode select.
- in_valid  input  1  imm/Eop are valid this cycle and are to be captured.
- stall  input  1  hold the registered output; blocks capture.
- ext  output  32  combinational extension of imm per Eop.
- ext_q  output  32  registered extension result.
- out_valid  output  1  ext_q holds a valid result.

Behaviour:
- Eop encoding, where s = imm[15]:
  - 2'b00, zero-extend: ext = {16'h0000, imm}.
  - 2'b01, sign-extend: ext = {{16{s}}, imm}.
  - 2'b10, load-upper: ext = {imm, 16'h0000}.
  - 2'b11, sign-extend then shift left 2 (branch offset): ext = {{14{s}}, imm, 2'b00}.
- ext is purely combinational.
  - Zero latency; no dependency on clk or rst_n.
  - Valid whenever imm and Eop are driven.
  - X/Z on Eop is not supported.
- Registered path, evaluated on each rising clk edge while rst_n = 1:
  - stall = 1: ext_q and out_valid hold their values; in_valid is ignored and that input is lost, not queued.
  - stall = 0 and in_valid = 1: ext_q <= ext computed from the current imm/Eop, and out_valid <= 1. Latency is 1 cycle.
  - stall = 0 and in_valid = 0: out_valid <= 0; ext_q holds its last value.
- Reset:
  - rst_n = 0 immediately forces ext_q = 32'h00000000 and out_valid = 0, independent of clk.
  - Reset asserted mid-operation discards any pending result.
  - After rst_n deasserts, the first capture requires a rising edge with in_valid = 1 and stall = 0.
  - ext is unaffected by reset.
- Boundary cases:
  - Zero-extend and load-upper never produce sign bits: imm = 16'hFFFF under Eop = 00 gives 32'h0000FFFF.
  - Mode 11 discards the top 2 bits of the sign-extended value; no overflow flag is produced.
  - Back-to-back in_valid with stall low gives a new result every cycle at full throughput.
  - in_valid and stall both high in the same cycle: stall wins.

Test Plan:
- Reset then basic zero-extend:
  - Assert rst_n = 0 -> ext_q = 0, out_valid = 0 with no clock edge.
  - Release, drive imm = 16'h0010, Eop = 00 -> ext = 32'h00000010 at once.
  - With in_valid = 1 -> ext_q = 32'h00000010 and out_valid = 1 after the next rising edge.
- All modes with a negative immediate (imm = 16'h8001):
  - Eop = 00 -> 32'h00008001.
  - Eop = 01 -> 32'hFFFF8001.
  - Eop = 10 -> 32'h80010000.
  - Eop = 11 -> 32'hFFFE0004.
- Positive sign-extend/branch (imm = 16'h7FFF):
  - Eop = 01 -> 32'h00007FFF.
  - Eop = 11 -> 32'h0001FFFC.
  - imm = 16'hFFFF, Eop = 11 -> 32'hFFFFFFFC.
- Stall hold:
  - Capture imm = 16'h1234, Eop = 10 -> ext_q = 32'h12340000.
  - Then stall = 1 with imm = 16'h5678 and in_valid = 1 for 3 cycles -> ext_q and out_valid unchanged.
  - Release stall -> ext_q = 32'h56780000 one cycle later.
- Valid drop and back-to-back:
  - in_valid = 1 on 3 consecutive cycles with Eop = 00, 01, 10 and imm = 16'hFFFF -> ext_q sequence 32'h0000FFFF, 32'hFFFFFFFF, 32'hFFFF0000.
  - in_valid = 0 afterwards -> out_valid = 0, ext_q holds 32'hFFFF0000.
- Asynchronous reset mid-stream:
  - Pulse rst_n low between clock edges while out_valid = 1 -> ext_q = 0 and out_valid = 0 immediately.
  - The combinational ext still tracks imm/Eop throughout.
